// File: rtl/blink_indicator_pkg.sv
// Shared definitions for the blink indicator: state encoding and duration-counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blink_indicator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } state_t;

  // Width of a counter that must hold 0 .. max(on_t, off_t).
  function automatic int cnt_width(input int on_t, input int off_t);
    int m;
    m = (on_t > off_t) ? on_t : off_t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/blink_indicator_sat_counter.sv
// Saturating up/down counter with sticky overflow flag for dropped increments.
// Latency: count and flag update on the clock edge after inc/dec/clr are sampled.
// Backpressure: none; an increment at full scale is dropped and flagged unless a decrement cancels it.
//
// Ports: clk, rst (async active-low), inc, dec, clr (sync flush of count and flag),
//        cnt (current count), ovf (sticky: an increment was dropped).
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  localparam logic [W-1:0] MAXV = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (cnt == MAXV) ovf <= 1'b1;
          else             cnt <= cnt + 1'b1;
        end
        2'b01: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        // inc and dec together cancel, even at full scale
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/blink_indicator.sv
// LED blink sequencer: each evt queues one blink of ON_TIME cycles followed by an OFF_TIME-cycle gap.
// Latency: evt in cycle t -> pend_cnt=1 after edge t -> led=1 after edge t+1.
// Backpressure: none; up to 2^PEND_W-1 blinks queue, further events are dropped and flagged in ovf.
//
// Ports: clk, rst (async active-low), evt (one blink per high cycle), clr (flush queue and ovf),
//        led (registered drive), busy (ON or GAP), pend_cnt (queued blinks), ovf (sticky drop flag).
module blink_indicator
  import blink_indicator_pkg::*;
#(
  parameter int ON_TIME  = 1250000,
  parameter int OFF_TIME = 1250000,
  parameter int PEND_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt,
  input  logic              clr,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam int CW = cnt_width(ON_TIME, OFF_TIME);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_TIME - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TIME - 1);

  state_t        state;
  logic [CW-1:0] dur;
  logic          pend_nz;
  logic          deq;

  assign pend_nz = (pend_cnt != '0);

  // A queued blink is taken when idle, or on the last gap cycle so blinks run back-to-back.
  always_comb begin
    deq = 1'b0;
    if (pend_nz) begin
      if (state == IDLE)                      deq = 1'b1;
      else if (state == GAP && dur == OFF_LAST) deq = 1'b1;
    end
  end

  sat_counter #(
    .W(PEND_W)
  ) u_pend (
    .clk (clk),
    .rst (rst),
    .inc (evt),
    .dec (deq),
    .clr (clr),
    .cnt (pend_cnt),
    .ovf (ovf)
  );

  // led/busy are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dur   <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_nz) begin
            state <= ON;
            dur   <= '0;
            led   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ON: begin
          if (dur == ON_LAST) begin
            state <= GAP;
            dur   <= '0;
            led   <= 1'b0;
          end else begin
            dur <= dur + 1'b1;
          end
        end
        GAP: begin
          if (dur == OFF_LAST) begin
            dur <= '0;
            if (pend_nz) begin
              state <= ON;
              led   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dur <= dur + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          dur   <= '0;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_indicator.sv
// Bench for blink_indicator: directed scenarios plus random evt/clr/reset traffic.
// Reference model tracks blinks as time windows [start, start+ON+OFF) and a pending count.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
module tb_blink_indicator;

  localparam int ON_T  = 4;
  localparam int OFF_T = 3;
  localparam int PW    = 2;
  localparam int MAXP  = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          evt = 1'b0;
  logic          clr = 1'b0;
  logic          led;
  logic          busy;
  logic [PW-1:0] pend_cnt;
  logic          ovf;

  blink_indicator #(
    .ON_TIME (ON_T),
    .OFF_TIME(OFF_T),
    .PEND_W  (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .evt     (evt),
    .clr     (clr),
    .led     (led),
    .busy    (busy),
    .pend_cnt(pend_cnt),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  int   m_pend   = 0;
  int   m_start  = -1;
  bit   m_ovf    = 1'b0;
  int   d_blinks = 0;
  logic prev_led = 1'b0;
  int   rises[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rise_at(input int idx);
    if (idx < rises.size()) return rises[idx];
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_ovf   = 1'b0;
    m_start = -1;
  endtask

  // One clock edge of the reference model, with inputs as sampled on that edge.
  task automatic model_edge(input logic e, input logic c);
    bit free, deq;
    free = (m_start < 0) || (cyc >= m_start + ON_T + OFF_T);
    deq  = free && (m_pend > 0);
    if (c) begin
      m_pend = 0;
      m_ovf  = 1'b0;
    end else if (e) begin
      if (!deq) begin
        if (m_pend == MAXP) m_ovf = 1'b1;
        else                m_pend++;
      end
    end else if (deq) begin
      m_pend--;
    end
    if (deq) m_start = cyc;
  endtask

  task automatic check_outputs();
    bit exp_led, exp_busy;
    exp_led  = (m_start >= 0) && (cyc - m_start < ON_T);
    exp_busy = (m_start >= 0) && (cyc - m_start < ON_T + OFF_T);
    chk("led", 32'(led), 32'(exp_led));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("pend_cnt", 32'(pend_cnt), 32'(m_pend));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (led === 1'b1 && prev_led !== 1'b1) begin
      d_blinks++;
      rises.push_back(cyc);
    end
    prev_led = led;
  endtask

  task automatic tick();
    logic e, c;
    @(posedge clk);
    e = evt;
    c = clr;
    cyc++;
    if (rst) model_edge(e, c);
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called 1 unit after an edge: reset takes effect with no clock edge, evt during reset is ignored.
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    evt = 1'b1;
    ticks(n);
    evt = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    int e0, base, idx, guard;

    // Reset phase, with evt asserted while in reset
    #2 rst = 1'b0;
    #1;
    check_outputs();
    evt = 1'b1;
    ticks(3);
    evt = 1'b0;
    rst = 1'b1;
    ticks(4);

    // Single event: led high 4 cycles starting one edge after the queue edge
    base = d_blinks; idx = rises.size();
    evt = 1'b1; e0 = cyc + 1;
    tick();
    evt = 1'b0;
    chk("single_pend1", 32'(pend_cnt), 32'd1);
    ticks(12);
    chk("single_rise", 32'(rise_at(idx)), 32'(e0 + 1));
    chk("single_count", 32'(d_blinks - base), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);

    // Burst of 3: back-to-back blinks 7 cycles apart
    base = d_blinks; idx = rises.size();
    evt = 1'b1; e0 = cyc + 1;
    ticks(3);
    evt = 1'b0;
    ticks(25);
    chk("burst_rise0", 32'(rise_at(idx)), 32'(e0 + 1));
    chk("burst_rise1", 32'(rise_at(idx + 1)), 32'(e0 + 8));
    chk("burst_rise2", 32'(rise_at(idx + 2)), 32'(e0 + 15));
    chk("burst_count", 32'(d_blinks - base), 32'd3);

    // Overflow: 7 consecutive events, queue saturates at 3
    base = d_blinks;
    evt = 1'b1;
    ticks(7);
    evt = 1'b0;
    chk("ovf_pend_sat", 32'(pend_cnt), 32'd3);
    chk("ovf_set", 32'(ovf), 32'd1);
    ticks(40);
    chk("ovf_count", 32'(d_blinks - base), 32'd4);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    ticks(3);

    // clr during gap with two blinks queued
    base = d_blinks;
    evt = 1'b1;
    ticks(3);
    evt = 1'b0;
    guard = 0;
    while (!(busy === 1'b1 && led === 1'b0) && guard < 20) begin
      tick();
      guard++;
    end
    chk("clr_gap_reached", 32'(guard < 20), 32'd1);
    chk("clr_pend_before", 32'(pend_cnt), 32'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_pend_zero", 32'(pend_cnt), 32'd0);
    chk("clr_still_gap", 32'(busy), 32'd1);
    ticks(15);
    chk("clr_count", 32'(d_blinks - base), 32'd1);

    // Reset in the 2nd ON cycle with one blink queued
    evt = 1'b1;
    ticks(2);
    evt = 1'b0;
    tick();
    chk("rst_pre_led", 32'(led), 32'd1);
    chk("rst_pre_pend", 32'(pend_cnt), 32'd1);
    do_reset(2);
    chk("rst_led_low", 32'(led), 32'd0);
    ticks(2);
    base = d_blinks;
    evt = 1'b1;
    tick();
    evt = 1'b0;
    ticks(12);
    chk("rst_after_count", 32'(d_blinks - base), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      evt = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0) begin
        clr = 1'b0;
        do_reset($urandom_range(1, 3));
      end else begin
        tick();
      end
    end
    evt = 1'b0;
    clr = 1'b0;
    ticks(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
